// File: rtl/csr_access_sched.sv
// csr_access_sched: shares one CSR execute path between NUM_REQS issue slices.
// Round-robin grant in IDLE. FPU CSRs wait in DRAIN until the warp has no
// pending instructions, and the issue handshake pulses a warp unlock.
//
// state | meaning
// IDLE  | arbitrate; accept one request and capture its fields
// DRAIN | FPU CSR: wait for alm_empty on the captured warp
// ISSUE | present captured request to the CSR unit until out_ready
module csr_access_sched #(
  parameter int                 NUM_REQS  = 4,
  parameter int                 NUM_WARPS = 4,
  parameter int                 ADDR_BITS = 12,
  parameter logic [ADDR_BITS-1:0] FCSR_ADDR = 12'h003,
  parameter int                 CNT_WIDTH = 32,
  localparam int                NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int                IDX_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*NW_BITS-1:0]   req_wid,
  input  logic [NUM_REQS*ADDR_BITS-1:0] req_addr,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic [NW_BITS-1:0]            alm_empty_wid,
  input  logic                          alm_empty,
  output logic                          out_valid,
  output logic [IDX_BITS-1:0]           out_idx,
  output logic [NW_BITS-1:0]            out_wid,
  output logic [ADDR_BITS-1:0]          out_addr,
  input  logic                          out_ready,
  output logic                          unlock_warp,
  output logic [NW_BITS-1:0]            unlock_wid,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          drain_stalls
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ISSUE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_BITS-1:0]   r_rr_ptr;
  logic [IDX_BITS-1:0]   r_idx;
  logic [NW_BITS-1:0]    r_wid;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_is_fpu;
  logic [CNT_WIDTH-1:0]  r_stalls;

  logic                  w_any;
  logic [NUM_REQS-1:0]   w_gnt_oh;
  logic [IDX_BITS-1:0]   w_gnt_idx;
  logic [NW_BITS-1:0]    w_gnt_wid;
  logic [ADDR_BITS-1:0]  w_gnt_addr;
  logic                  w_accept;
  logic                  w_issue_done;
  int                    w_best;
  int                    w_dist;

  // Round-robin pick: the valid slice closest to rr_ptr (modular distance) wins.
  always_comb begin
    w_any      = 1'b0;
    w_gnt_oh   = '0;
    w_gnt_idx  = '0;
    w_gnt_wid  = '0;
    w_gnt_addr = '0;
    w_best     = NUM_REQS;
    w_dist     = 0;
    for (int j = 0; j < NUM_REQS; j++) begin
      w_dist = (j + NUM_REQS - int'(r_rr_ptr)) % NUM_REQS;
      if (req_valid[j] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_any      = 1'b1;
        w_gnt_oh   = NUM_REQS'(1) << j;
        w_gnt_idx  = IDX_BITS'(j);
        w_gnt_wid  = req_wid[j*NW_BITS +: NW_BITS];
        w_gnt_addr = req_addr[j*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; grants are masked while reset is held.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = '0;
    out_valid    = 1'b0;
    unlock_warp  = 1'b0;
    w_accept     = 1'b0;
    w_issue_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && reset) begin
          req_ready   = w_gnt_oh;
          w_accept    = 1'b1;
          w_state_nxt = (w_gnt_addr <= FCSR_ADDR) ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (alm_empty) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_issue_done = 1'b1;
          unlock_warp  = r_is_fpu;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the granted request; advance the pointer only when the issue completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_wid    <= '0;
      r_addr   <= '0;
      r_is_fpu <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx    <= w_gnt_idx;
        r_wid    <= w_gnt_wid;
        r_addr   <= w_gnt_addr;
        r_is_fpu <= (w_gnt_addr <= FCSR_ADDR);
      end
      if (w_issue_done) begin
        r_rr_ptr <= (r_idx == IDX_BITS'(NUM_REQS - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Saturating count of cycles stuck in DRAIN waiting for the warp to empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stalls <= '0;
    end else if ((r_state == S_DRAIN) && !alm_empty && (r_stalls != '1)) begin
      r_stalls <= r_stalls + 1'b1;
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign alm_empty_wid = r_wid;
  assign out_idx       = r_idx;
  assign out_wid       = r_wid;
  assign out_addr      = r_addr;
  assign unlock_wid    = r_wid;
  assign drain_stalls  = r_stalls;

endmodule

// File: tb/tb_csr_access_sched.sv
// Bench for csr_access_sched: arbitration table, directed corner sequences,
// then a randomized run against a transaction-level reference model.
module tb_csr_access_sched;

  localparam int NR = 4;
  localparam int NW = 2;
  localparam int AW = 12;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*NW-1:0] req_wid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_ready;
  logic [NW-1:0]   alm_empty_wid;
  logic            alm_empty;
  logic            out_valid;
  logic [1:0]      out_idx;
  logic [NW-1:0]   out_wid;
  logic [AW-1:0]   out_addr;
  logic            out_ready;
  logic            unlock_warp;
  logic [NW-1:0]   unlock_wid;
  logic            busy;
  logic [CW-1:0]   drain_stalls;

  csr_access_sched #(.NUM_REQS(NR), .NUM_WARPS(4), .ADDR_BITS(AW),
                     .FCSR_ADDR(12'h003), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wid(req_wid),
    .req_addr(req_addr), .req_ready(req_ready), .alm_empty_wid(alm_empty_wid),
    .alm_empty(alm_empty), .out_valid(out_valid), .out_idx(out_idx),
    .out_wid(out_wid), .out_addr(out_addr), .out_ready(out_ready),
    .unlock_warp(unlock_warp), .unlock_wid(unlock_wid), .busy(busy),
    .drain_stalls(drain_stalls)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [NW-1:0] s_wid  [NR];
  logic [AW-1:0] s_addr [NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_wid[i*NW +: NW]  = s_wid[i];
      req_addr[i*AW +: AW] = s_addr[i];
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0; alm_empty = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin s_wid[i] = '0; s_addr[i] = 12'h800; end
    drive();
    next(); next();
    reset = 1'b1;
    #1;
  endtask

  // One non-FPU access from slice s, leaving the round-robin pointer at s+1.
  task automatic do_txn(input int s);
    req_valid = 4'b0001 << s; s_addr[s] = 12'h800; drive(); out_ready = 1'b1;
    next();
    req_valid = '0;
    next();
  endtask

  typedef struct {
    int         start;
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } arb_vec_t;

  arb_vec_t tbl[9];

  // reference model state
  bit          m_busy, m_drain, m_fpu;
  int          m_rr, m_idx, m_st;
  logic [NW-1:0] m_wid;
  logic [AW-1:0] m_addr;
  logic [3:0]  s_v;

  initial begin
    tbl[0] = '{0, 4'b0000, 4'b0000};
    tbl[1] = '{0, 4'b1111, 4'b0001};
    tbl[2] = '{1, 4'b1111, 4'b0010};
    tbl[3] = '{2, 4'b1001, 4'b1000};
    tbl[4] = '{3, 4'b0110, 4'b0010};
    tbl[5] = '{1, 4'b0001, 4'b0001};
    tbl[6] = '{2, 4'b0011, 4'b0001};
    tbl[7] = '{3, 4'b1000, 4'b1000};
    tbl[8] = '{0, 4'b1100, 4'b0100};

    // Reset values, including a request presented while reset is held.
    reset = 1'b0; req_valid = 4'b1111; alm_empty = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin s_wid[i] = 2'd3; s_addr[i] = 12'h001; end
    drive();
    #12;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_unlock", 32'(unlock_warp), 0);
    chk("rst_stalls", 32'(drain_stalls), 0);
    chk("rst_fields", {out_idx, out_wid, out_addr, alm_empty_wid, unlock_wid}, 0);

    // Arbitration table.
    for (int t = 0; t < 9; t++) begin
      do_reset();
      if (tbl[t].start != 0) do_txn((tbl[t].start + 3) % 4);
      req_valid = tbl[t].valid; out_ready = 1'b1;
      #1;
      chk($sformatf("arb_tbl%0d", t), 32'(req_ready), 32'(tbl[t].exp_ready));
      next();
      req_valid = '0;
      if (tbl[t].exp_ready != 0) next();
    end

    // Plan 1: single non-FPU request from slice 2.
    do_reset();
    s_wid[2] = 2'd1; s_addr[2] = 12'hCC0; drive();
    req_valid = 4'b0100; out_ready = 1'b1;
    #1;
    chk("p1_ready", 32'(req_ready), 32'h4);
    next();
    req_valid = '0; #1;
    chk("p1_out_valid", 32'(out_valid), 1);
    chk("p1_out_idx", 32'(out_idx), 2);
    chk("p1_out_wid", 32'(out_wid), 1);
    chk("p1_out_addr", 32'(out_addr), 32'hCC0);
    chk("p1_unlock", 32'(unlock_warp), 0);
    next();
    req_valid = 4'b1111; #1;
    chk("p1_rr_ptr3", 32'(req_ready), 32'h8);
    next(); req_valid = '0; next();

    // Plan 2: all four slices hold valid; grants rotate every 2 cycles.
    do_reset();
    for (int i = 0; i < NR; i++) s_addr[i] = 12'h100 + 12'(i);
    drive();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("p2_grant%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      next();
      chk($sformatf("p2_issue%0d", k), {31'(out_idx), out_valid}, {31'(k % 4), 1'b1});
      next();
    end
    req_valid = '0;

    // Plan 3: FPU CSR with 5 drain stalls.
    do_reset();
    s_wid[1] = 2'd2; s_addr[1] = 12'h003; drive();
    req_valid = 4'b0010; out_ready = 1'b1;
    #1;
    chk("p3_ready", 32'(req_ready), 32'h2);
    next();
    req_valid = '0; alm_empty = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("p3_drain_wid", 32'(alm_empty_wid), 2);
      chk("p3_drain_noout", {out_valid, unlock_warp, busy}, 3'b001);
      next();
    end
    alm_empty = 1'b1; #1;
    chk("p3_drain_last", {30'(alm_empty_wid), out_valid, busy}, {30'd2, 2'b01});
    next();
    chk("p3_out_valid", 32'(out_valid), 1);
    chk("p3_unlock", {30'(unlock_wid), unlock_warp, 1'b0}, {30'd2, 1'b1, 1'b0});
    chk("p3_stalls", 32'(drain_stalls), 5);
    next();
    chk("p3_idle", {busy, unlock_warp}, 0);

    // Plan 4: issue held by out_ready=0.
    do_reset();
    s_addr[0] = 12'h7A5; s_wid[0] = 2'd3; drive();
    req_valid = 4'b0001; out_ready = 1'b0;
    next();
    req_valid = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("p4_hold_valid", {out_valid, busy}, 2'b11);
      chk("p4_hold_fields", {28'(out_addr), out_wid, out_idx}, {28'h7A5, 2'd3, 2'd0});
      chk("p4_hold_noready", 32'(req_ready), 0);
      next();
    end
    out_ready = 1'b1; #1;
    chk("p4_hs", {out_valid, unlock_warp}, 2'b10);
    next();
    chk("p4_idle_rr", {busy, req_ready}, {1'b0, 4'b0010});
    next(); req_valid = '0; next();

    // Plan 5: reset during DRAIN drops the request.
    do_reset();
    s_addr[3] = 12'h002; s_wid[3] = 2'd3; drive();
    req_valid = 4'b1000; out_ready = 1'b1; alm_empty = 1'b0;
    next();
    req_valid = '0;
    next(); next();
    chk("p5_pre_stalls", 32'(drain_stalls), 2);
    #2 reset = 1'b0; #1;
    chk("p5_reset", {busy, unlock_warp, out_valid, drain_stalls}, 0);
    next();
    reset = 1'b1; alm_empty = 1'b1; req_valid = 4'b1111; #1;
    chk("p5_restart", 32'(req_ready), 32'h1);
    next(); req_valid = '0; next();
    chk("p5_no_unlock", {busy, unlock_warp}, 0);

    // Plan 6: stall counter saturates at 4'hF.
    do_reset();
    s_addr[0] = 12'h000; drive();
    req_valid = 4'b0001; alm_empty = 1'b0; out_ready = 1'b1;
    next();
    req_valid = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == 14) chk("p6_stalls14", 32'(drain_stalls), 14);
      next();
    end
    chk("p6_saturate", 32'(drain_stalls), 32'hF);
    alm_empty = 1'b1; next();
    chk("p6_out", {out_valid, unlock_warp}, 2'b11);
    next();

    // Randomized run against the reference model.
    do_reset();
    m_busy = 0; m_drain = 0; m_fpu = 0; m_rr = 0; m_idx = 0; m_st = 0;
    m_wid = '0; m_addr = '0; s_v = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int g;
      logic [3:0] exp_ready;
      bit exp_unlock;
      req_valid = s_v; drive();
      alm_empty = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      g = -1;
      if (!m_busy)
        for (int k = 0; k < NR; k++)
          if (g < 0 && s_v[(m_rr + k) % NR]) g = (m_rr + k) % NR;
      exp_ready  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      exp_unlock = m_busy && !m_drain && out_ready && m_fpu;
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_state", {busy, out_valid, unlock_warp},
          {m_busy, m_busy && !m_drain, exp_unlock});
      chk("rnd_stalls", 32'(drain_stalls), 32'(m_st));
      if (m_busy)
        chk("rnd_fields", {16'(out_addr), 4'(out_idx), 4'(out_wid), 4'(alm_empty_wid), 4'(unlock_wid)},
            {16'(m_addr), 4'(m_idx), 4'(m_wid), 4'(m_wid), 4'(m_wid)});
      if (g >= 0) begin
        m_busy = 1; m_idx = g; m_wid = s_wid[g]; m_addr = s_addr[g];
        m_fpu = (m_addr <= 12'h003); m_drain = m_fpu;
      end else if (m_busy && m_drain) begin
        if (alm_empty) m_drain = 0;
        else if (m_st < 15) m_st++;
      end else if (m_busy && out_ready) begin
        m_busy = 0; m_rr = (m_idx + 1) % NR;
      end
      for (int i = 0; i < NR; i++) begin
        if (i == g || !s_v[i]) begin
          s_v[i] = (i == g) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) < 3);
          s_wid[i] = 2'($urandom_range(0, 3));
          s_addr[i] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 5)) : 12'($urandom);
        end
      end
      next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
